kianv_mem_responder: RTL and testbench
======================================

// Module: kianv_mem_responder
// PURPOSE
//  Target end of the CPU memory bus (valid/ready, 34-bit phys addr, wstrb, wdata/rdata, access_fault).
//  Accepts one request at a time, decodes it to RAM or IO target port, waits on that target's handshake,
//  returns a one-cycle mem_ready pulse with registered rdata. Unmapped addresses answer with access_fault.
//  Sits between the sv32 MMU output and the SoC RAM controller / IO interconnect.
// PARAMETERS
//  RAM_BASE        32'h8000_0000  RAM region base (aligned to 2**RAM_SIZE_LOG2)
//  RAM_SIZE_LOG2   24             RAM region size, log2 bytes
//  IO_BASE         32'h1000_0000  IO region base (aligned to 2**IO_SIZE_LOG2)
//  IO_SIZE_LOG2    24             IO region size, log2 bytes
//  TIMEOUT_CYCLES  1024           target wait limit (used only with BUS_TIMEOUT_EN)
// PORTS
//  clk           in   1   clock
//  resetn        in   1   synchronous reset, active low
//  mem_valid     in   1   request valid; initiator holds it and all request fields stable until mem_ready
//  mem_ready     out  1   one-cycle response strobe
//  mem_wstrb     in   4   byte write strobes; 0 = read
//  mem_addr      in   34  physical byte address
//  mem_wdata     in   32  write data
//  mem_rdata     out  32  read data, valid while mem_ready=1, held until next response
//  access_fault  out  1   asserted only together with mem_ready; request not performed
//  ram_valid/io_valid    out 1   target request valid (at most one high)
//  ram_ready/io_ready    in  1   target completion; ignored while matching *_valid=0
//  tgt_addr      out  32  region offset (mem_addr minus region base), word-aligned [1:0]=0
//  tgt_wstrb     out  4   registered copy of mem_wstrb
//  tgt_wdata     out  32  registered copy of mem_wdata
//  ram_rdata/io_rdata    in  32  target read data, sampled on *_ready
// BEHAVIOUR
//  Reset (resetn=0 at posedge): state IDLE; mem_ready, access_fault, ram_valid, io_valid = 0;
//   mem_rdata, tgt_addr, tgt_wstrb, tgt_wdata = 0; timeout counter = 0. Applies mid-transaction:
//   target valid drops at that edge, no response is issued for the aborted request.
//  FSM: IDLE -> DECODE -> WAIT -> RESP -> IDLE; DECODE -> RESP on fault.
//  IDLE: mem_valid=1 -> register addr/wstrb/wdata, go DECODE.
//  DECODE: region select on registered addr. Hit requires addr[33:32]==0 and
//   addr[31:SIZE_LOG2]==BASE[31:SIZE_LOG2]. RAM hit -> ram_valid=1; IO hit -> io_valid=1; go WAIT.
//   No hit -> access_fault staged, mem_rdata=0, go RESP; no target sees the request.
//  WAIT: selected *_valid held, tgt_* stable. On *_ready: *_valid=0 next edge, capture *_rdata
//   (writes capture 0), go RESP.
//  RESP: mem_ready=1 for exactly one cycle (access_fault=1 if faulted), then IDLE.
//  IDLE samples mem_valid again the cycle after RESP; a still-high valid there is a new request.
//  Latency: valid seen at cycle N, target ready at earliest N+2 combinational; mem_ready at N+3 when
//   target ready is immediate; fault response mem_ready at N+2.
//  mem_valid falling before mem_ready is a protocol violation; block completes the request anyway.
//  Overlapping RAM/IO regions: RAM takes priority.
//  tgt_addr arithmetic: 32-bit, upper bits above SIZE_LOG2 are zero by construction.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined: counter clears on WAIT entry, increments each WAIT cycle without *_ready;
//   on reaching TIMEOUT_CYCLES: drop *_valid, mem_rdata=0, go RESP with access_fault=1.
//   *_ready in the expiry cycle wins -> normal response. Counter width $clog2(TIMEOUT_CYCLES+1).
//  BUS_TIMEOUT_EN undefined: no counter; WAIT lasts until *_ready, indefinitely.
// TESTING
//  RAM read: addr 34'h0_8000_0010, wstrb 0, ram_ready at 1st WAIT cycle, ram_rdata 32'hDEADBEEF
//   -> tgt_addr 32'h10, mem_ready 3 cycles after valid, mem_rdata DEADBEEF, access_fault 0.
//  IO write: addr 34'h0_1000_0004, wstrb 4'b0011, wdata 32'h1234_5678, io_ready after 5 cycles
//   -> io_valid held 5 cycles, tgt_wstrb 0011, tgt_wdata 12345678, single mem_ready pulse.
//  Unmapped: addr 34'h1_8000_0000 and 34'h0_4000_0000 -> mem_ready+access_fault 2 cycles after
//   valid, ram_valid/io_valid never high, mem_rdata 0.
//  Back-to-back: mem_valid held high across two requests -> two distinct mem_ready pulses,
//   second request's fields captured in the IDLE cycle after first RESP.
//  Reset mid-WAIT: resetn=0 while ram_valid=1 -> ram_valid 0 next edge, no mem_ready, all outputs 0.
//  BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, ram_ready never -> access_fault+mem_ready after 8 WAIT cycles;
//   repeat with ram_ready on 8th cycle -> normal response, access_fault 0.

Source files
------------

// File: rtl/kianv_mem_responder.sv
// kianv_mem_responder: target end of the CPU memory bus.
// Accepts one valid/ready request at a time. It decodes the physical address to the RAM or IO
// target port, waits for that target's handshake and returns a one-cycle mem_ready pulse with
// registered read data. An address outside both regions completes with access_fault.
// Optional feature: define BUS_TIMEOUT_EN to bound the target wait to TIMEOUT_CYCLES cycles.
// All outputs are registered. Reset is synchronous and active low (resetn).

module kianv_mem_responder #(
    parameter logic [31:0] RAM_BASE       = 32'h8000_0000,
    parameter int unsigned RAM_SIZE_LOG2  = 24,
    parameter logic [31:0] IO_BASE        = 32'h1000_0000,
    parameter int unsigned IO_SIZE_LOG2   = 24,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    // initiator side
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_wstrb,
    input  logic [33:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        access_fault,
    // target side
    output logic        ram_valid,
    input  logic        ram_ready,
    input  logic [31:0] ram_rdata,
    output logic        io_valid,
    input  logic        io_ready,
    input  logic [31:0] io_rdata,
    output logic [31:0] tgt_addr,
    output logic [3:0]  tgt_wstrb,
    output logic [31:0] tgt_wdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [33:0] addr_q, addr_d;
    logic        mem_ready_q, mem_ready_d;
    logic        access_fault_q, access_fault_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        ram_valid_q, ram_valid_d;
    logic        io_valid_q, io_valid_d;
    logic [31:0] tgt_addr_q, tgt_addr_d;
    logic [3:0]  tgt_wstrb_q, tgt_wstrb_d;
    logic [31:0] tgt_wdata_q, tgt_wdata_d;

    // Region decode on the registered address; the offset subtraction is only used on a hit,
    // where it reduces to the low SIZE_LOG2 bits of the address.
    logic        ram_hit_s;
    logic        io_hit_s;
    logic [31:0] ram_off_s;
    logic [31:0] io_off_s;
    logic        tgt_ready_s;
    logic [31:0] tgt_rdata_s;
    logic        is_write_s;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    // Value held during the last allowed WAIT cycle; a miss there expires the request.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    // TIMEOUT_CYCLES has no effect without BUS_TIMEOUT_EN; WAIT lasts until the target answers.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_disabled
    end
`endif

    // Address decode and target handshake selection.
    always_comb begin
        ram_hit_s   = (addr_q[33:32] == 2'b00) &&
                      ((addr_q[31:0] >> RAM_SIZE_LOG2) == (RAM_BASE >> RAM_SIZE_LOG2));
        io_hit_s    = (addr_q[33:32] == 2'b00) &&
                      ((addr_q[31:0] >> IO_SIZE_LOG2) == (IO_BASE >> IO_SIZE_LOG2));
        ram_off_s   = addr_q[31:0] - RAM_BASE;
        io_off_s    = addr_q[31:0] - IO_BASE;
        tgt_ready_s = (ram_valid_q & ram_ready) | (io_valid_q & io_ready);
        if (ram_valid_q) begin
            tgt_rdata_s = ram_rdata;
        end else begin
            tgt_rdata_s = io_rdata;
        end
        is_write_s  = (tgt_wstrb_q != 4'b0000);
    end

    // Next-state and registered-output logic of the request FSM.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        mem_ready_d    = 1'b0;
        access_fault_d = 1'b0;
        mem_rdata_d    = mem_rdata_q;
        ram_valid_d    = ram_valid_q;
        io_valid_d     = io_valid_q;
        tgt_addr_d     = tgt_addr_q;
        tgt_wstrb_d    = tgt_wstrb_q;
        tgt_wdata_d    = tgt_wdata_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d          = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    addr_d      = mem_addr;
                    tgt_wstrb_d = mem_wstrb;
                    tgt_wdata_d = mem_wdata;
                    state_d     = ST_DECODE;
                end else begin
                    state_d     = ST_IDLE;
                end
            end

            ST_DECODE: begin
`ifdef BUS_TIMEOUT_EN
                cnt_d = '0;
`endif
                // RAM is checked first so it wins if the regions overlap.
                if (ram_hit_s) begin
                    ram_valid_d = 1'b1;
                    tgt_addr_d  = ram_off_s & 32'hFFFF_FFFC;
                    state_d     = ST_WAIT;
                end else if (io_hit_s) begin
                    io_valid_d  = 1'b1;
                    tgt_addr_d  = io_off_s & 32'hFFFF_FFFC;
                    state_d     = ST_WAIT;
                end else begin
                    mem_ready_d    = 1'b1;
                    access_fault_d = 1'b1;
                    mem_rdata_d    = 32'h0000_0000;
                    state_d        = ST_RESP;
                end
            end

            ST_WAIT: begin
                if (tgt_ready_s) begin
                    ram_valid_d = 1'b0;
                    io_valid_d  = 1'b0;
                    mem_ready_d = 1'b1;
                    if (is_write_s) begin
                        mem_rdata_d = 32'h0000_0000;
                    end else begin
                        mem_rdata_d = tgt_rdata_s;
                    end
                    state_d = ST_RESP;
`ifdef BUS_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    ram_valid_d    = 1'b0;
                    io_valid_d     = 1'b0;
                    mem_ready_d    = 1'b1;
                    access_fault_d = 1'b1;
                    mem_rdata_d    = 32'h0000_0000;
                    state_d        = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_WAIT;
                end
`else
                end else begin
                    state_d = ST_WAIT;
                end
`endif
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                ram_valid_d = 1'b0;
                io_valid_d  = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            addr_q         <= 34'h0_0000_0000;
            mem_ready_q    <= 1'b0;
            access_fault_q <= 1'b0;
            mem_rdata_q    <= 32'h0000_0000;
            ram_valid_q    <= 1'b0;
            io_valid_q     <= 1'b0;
            tgt_addr_q     <= 32'h0000_0000;
            tgt_wstrb_q    <= 4'b0000;
            tgt_wdata_q    <= 32'h0000_0000;
`ifdef BUS_TIMEOUT_EN
            cnt_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            mem_ready_q    <= mem_ready_d;
            access_fault_q <= access_fault_d;
            mem_rdata_q    <= mem_rdata_d;
            ram_valid_q    <= ram_valid_d;
            io_valid_q     <= io_valid_d;
            tgt_addr_q     <= tgt_addr_d;
            tgt_wstrb_q    <= tgt_wstrb_d;
            tgt_wdata_q    <= tgt_wdata_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q          <= cnt_d;
`endif
        end
    end

    assign mem_ready    = mem_ready_q;
    assign access_fault = access_fault_q;
    assign mem_rdata    = mem_rdata_q;
    assign ram_valid    = ram_valid_q;
    assign io_valid     = io_valid_q;
    assign tgt_addr     = tgt_addr_q;
    assign tgt_wstrb    = tgt_wstrb_q;
    assign tgt_wdata    = tgt_wdata_q;

endmodule

// File: tb/tb_kianv_mem_responder.sv
// Directed self-checking bench for kianv_mem_responder.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled at the same point.
// Scenario tasks: reset, RAM read, unmapped, IO write, back-to-back, reset mid-WAIT, timeout (BUS_TIMEOUT_EN).

module tb_kianv_mem_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_wstrb;
    logic [33:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        access_fault;
    logic        ram_valid;
    logic        ram_ready;
    logic [31:0] ram_rdata;
    logic        io_valid;
    logic        io_ready;
    logic [31:0] io_rdata;
    logic [31:0] tgt_addr;
    logic [3:0]  tgt_wstrb;
    logic [31:0] tgt_wdata;

    int total = 0;
    int bad   = 0;

    kianv_mem_responder #(
        .RAM_BASE      (32'h8000_0000),
        .RAM_SIZE_LOG2 (24),
        .IO_BASE       (32'h1000_0000),
        .IO_SIZE_LOG2  (24),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_wstrb   (mem_wstrb),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .access_fault(access_fault),
        .ram_valid   (ram_valid),
        .ram_ready   (ram_ready),
        .ram_rdata   (ram_rdata),
        .io_valid    (io_valid),
        .io_ready    (io_ready),
        .io_rdata    (io_rdata),
        .tgt_addr    (tgt_addr),
        .tgt_wstrb   (tgt_wstrb),
        .tgt_wdata   (tgt_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        resetn    = 1'b0;
        mem_valid = 1'b1;
        mem_wstrb = 4'b1111;
        mem_addr  = 34'h0_8000_0020;
        mem_wdata = 32'hFFFF_FFFF;
        ram_ready = 1'b0;
        ram_rdata = 32'h0000_0000;
        io_ready  = 1'b0;
        io_rdata  = 32'h0000_0000;
        tick();
        tick();
        total++;
        if ({mem_ready, access_fault, ram_valid, io_valid} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000", {mem_ready, access_fault, ram_valid, io_valid});
        end
        total++;
        if ({mem_rdata, tgt_addr} !== 64'h0) begin
            bad++;
            $display("FAIL reset_data: rdata=%h tgt_addr=%h want 0", mem_rdata, tgt_addr);
        end
        total++;
        if ({tgt_wstrb, tgt_wdata} !== 36'h0) begin
            bad++;
            $display("FAIL reset_tgt: wstrb=%b wdata=%h want 0", tgt_wstrb, tgt_wdata);
        end
        mem_valid = 1'b0;
        resetn    = 1'b1;
        tick();
    endtask

    task automatic test_ram_read;
        mem_valid = 1'b1;
        mem_addr  = 34'h0_8000_0010;
        mem_wstrb = 4'b0000;
        mem_wdata = 32'h0000_0000;
        tick();                        // DECODE
        total++;
        if ({ram_valid, mem_ready} !== 2'b00) begin
            bad++;
            $display("FAIL ram_rd_decode: valid/ready=%b want 00", {ram_valid, mem_ready});
        end
        tick();                        // first WAIT cycle
        total++;
        if ({ram_valid, io_valid, tgt_addr} !== {2'b10, 32'h0000_0010}) begin
            bad++;
            $display("FAIL ram_rd_wait: ram_v=%b io_v=%b tgt_addr=%h want 1 0 00000010",
                     ram_valid, io_valid, tgt_addr);
        end
        ram_ready = 1'b1;
        ram_rdata = 32'hDEAD_BEEF;
        tick();                        // RESP
        ram_ready = 1'b0;
        ram_rdata = 32'h0000_0000;
        total++;
        if ({mem_ready, access_fault, ram_valid, mem_rdata} !== {3'b100, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL ram_rd_resp: ready=%b fault=%b ram_v=%b rdata=%h want 1 0 0 deadbeef",
                     mem_ready, access_fault, ram_valid, mem_rdata);
        end
        mem_valid = 1'b0;
        tick();                        // IDLE
        total++;
        if ({mem_ready, mem_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL ram_rd_hold: ready=%b rdata=%h want 0 deadbeef", mem_ready, mem_rdata);
        end
    endtask

    task automatic test_unmapped;
        logic [33:0] addrs [2];
        addrs[0] = 34'h1_8000_0000;
        addrs[1] = 34'h0_4000_0000;
        for (int i = 0; i < 2; i++) begin
            mem_valid = 1'b1;
            mem_addr  = addrs[i];
            mem_wstrb = 4'b0000;
            tick();                    // DECODE
            total++;
            if ({mem_ready, ram_valid, io_valid} !== 3'b000) begin
                bad++;
                $display("FAIL unmapped_decode[%0d]: ready/ram_v/io_v=%b want 000", i,
                         {mem_ready, ram_valid, io_valid});
            end
            tick();                    // RESP
            total++;
            if ({mem_ready, access_fault, ram_valid, io_valid, mem_rdata} !== {4'b1100, 32'h0}) begin
                bad++;
                $display("FAIL unmapped_resp[%0d]: ready=%b fault=%b ram_v=%b io_v=%b rdata=%h want 1 1 0 0 0",
                         i, mem_ready, access_fault, ram_valid, io_valid, mem_rdata);
            end
            mem_valid = 1'b0;
            tick();
            total++;
            if ({mem_ready, access_fault} !== 2'b00) begin
                bad++;
                $display("FAIL unmapped_after[%0d]: ready/fault=%b want 00", i, {mem_ready, access_fault});
            end
        end
    endtask

    task automatic test_io_write;
        int ready_pulses;
        int io_high;
        ready_pulses = 0;
        io_high      = 0;
        mem_valid = 1'b1;
        mem_addr  = 34'h0_1000_0004;
        mem_wstrb = 4'b0011;
        mem_wdata = 32'h1234_5678;
        tick();                        // DECODE
        tick();                        // WAIT cycle 1
        total++;
        if ({ram_valid, tgt_addr, tgt_wstrb, tgt_wdata} !== {1'b0, 32'h0000_0004, 4'b0011, 32'h1234_5678}) begin
            bad++;
            $display("FAIL io_wr_tgt: ram_v=%b addr=%h wstrb=%b wdata=%h want 0 00000004 0011 12345678",
                     ram_valid, tgt_addr, tgt_wstrb, tgt_wdata);
        end
        for (int c = 1; c <= 6; c++) begin
            if (io_valid === 1'b1) io_high++;
            if (mem_ready === 1'b1) ready_pulses++;
            if (c == 5) begin
                io_ready = 1'b1;
                io_rdata = 32'hAAAA_5555;
            end else begin
                io_ready = 1'b0;
            end
            if (c == 6) mem_valid = 1'b0;
            tick();
            if (c == 5) begin
                total++;
                if ({mem_ready, access_fault, io_valid, mem_rdata} !== {3'b100, 32'h0}) begin
                    bad++;
                    $display("FAIL io_wr_resp: ready=%b fault=%b io_v=%b rdata=%h want 1 0 0 0",
                             mem_ready, access_fault, io_valid, mem_rdata);
                end
            end
        end
        io_ready = 1'b0;
        total++;
        if (io_high !== 5) begin
            bad++;
            $display("FAIL io_wr_valid_len: got %0d cycles want 5", io_high);
        end
        total++;
        if (ready_pulses !== 1 || mem_ready !== 1'b0) begin
            bad++;
            $display("FAIL io_wr_pulse: pulses=%0d ready_now=%b want 1 0", ready_pulses, mem_ready);
        end
    endtask

    task automatic test_back_to_back;
        mem_valid = 1'b1;
        mem_addr  = 34'h0_8000_0100;
        mem_wstrb = 4'b0000;
        tick();                        // DECODE #1
        tick();                        // WAIT #1
        ram_ready = 1'b1;
        ram_rdata = 32'h1111_1111;
        tick();                        // RESP #1
        ram_ready = 1'b0;
        total++;
        if ({mem_ready, mem_rdata} !== {1'b1, 32'h1111_1111}) begin
            bad++;
            $display("FAIL b2b_first: ready=%b rdata=%h want 1 11111111", mem_ready, mem_rdata);
        end
        mem_addr = 34'h0_1000_0020;    // second request, valid stays high
        tick();                        // IDLE, samples request #2
        total++;
        if ({mem_ready, ram_valid, io_valid} !== 3'b000) begin
            bad++;
            $display("FAIL b2b_gap: ready/ram_v/io_v=%b want 000", {mem_ready, ram_valid, io_valid});
        end
        tick();                        // DECODE #2
        tick();                        // WAIT #2
        total++;
        if ({io_valid, ram_valid, tgt_addr} !== {2'b10, 32'h0000_0020}) begin
            bad++;
            $display("FAIL b2b_second_wait: io_v=%b ram_v=%b addr=%h want 1 0 00000020",
                     io_valid, ram_valid, tgt_addr);
        end
        io_ready = 1'b1;
        io_rdata = 32'h2222_2222;
        tick();                        // RESP #2
        io_ready  = 1'b0;
        mem_valid = 1'b0;
        total++;
        if ({mem_ready, access_fault, mem_rdata} !== {2'b10, 32'h2222_2222}) begin
            bad++;
            $display("FAIL b2b_second_resp: ready=%b fault=%b rdata=%h want 1 0 22222222",
                     mem_ready, access_fault, mem_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait;
        int ready_seen;
        ready_seen = 0;
        mem_valid = 1'b1;
        mem_addr  = 34'h0_8000_0040;
        mem_wstrb = 4'b1111;
        mem_wdata = 32'h5A5A_5A5A;
        tick();
        tick();
        total++;
        if (ram_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_wait_pre: ram_valid=%b want 1", ram_valid);
        end
        resetn    = 1'b0;
        mem_valid = 1'b0;
        tick();
        total++;
        if ({mem_ready, access_fault, ram_valid, io_valid, mem_rdata, tgt_addr, tgt_wstrb, tgt_wdata} !== 104'h0) begin
            bad++;
            $display("FAIL rst_wait_outputs: ready=%b fault=%b ram_v=%b io_v=%b rdata=%h addr=%h wstrb=%b wdata=%h want all 0",
                     mem_ready, access_fault, ram_valid, io_valid, mem_rdata, tgt_addr, tgt_wstrb, tgt_wdata);
        end
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (mem_ready === 1'b1 || ram_valid === 1'b1) ready_seen++;
        end
        total++;
        if (ready_seen !== 0) begin
            bad++;
            $display("FAIL rst_wait_no_resp: activity cycles=%0d want 0", ready_seen);
        end
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout;
        for (int run = 0; run < 2; run++) begin
            int early;
            early     = 0;
            mem_valid = 1'b1;
            mem_addr  = 34'h0_8000_0000;
            mem_wstrb = 4'b0000;
            ram_ready = 1'b0;
            tick();                    // DECODE
            tick();                    // WAIT cycle 1
            for (int k = 1; k <= 7; k++) begin
                if (ram_valid !== 1'b1 || mem_ready !== 1'b0) early++;
                tick();
            end
            // now in WAIT cycle 8
            if (ram_valid !== 1'b1 || mem_ready !== 1'b0) early++;
            total++;
            if (early !== 0) begin
                bad++;
                $display("FAIL timeout_wait[%0d]: bad wait cycles=%0d want 0", run, early);
            end
            if (run == 1) begin
                ram_ready = 1'b1;
                ram_rdata = 32'hCAFE_F00D;
            end else begin
                ram_ready = 1'b0;
            end
            tick();                    // RESP
            ram_ready = 1'b0;
            mem_valid = 1'b0;
            total++;
            if (run == 0) begin
                if ({mem_ready, access_fault, ram_valid, mem_rdata} !== {3'b110, 32'h0}) begin
                    bad++;
                    $display("FAIL timeout_expire: ready=%b fault=%b ram_v=%b rdata=%h want 1 1 0 0",
                             mem_ready, access_fault, ram_valid, mem_rdata);
                end
            end else begin
                if ({mem_ready, access_fault, ram_valid, mem_rdata} !== {3'b100, 32'hCAFE_F00D}) begin
                    bad++;
                    $display("FAIL timeout_last_ready: ready=%b fault=%b ram_v=%b rdata=%h want 1 0 0 cafef00d",
                             mem_ready, access_fault, ram_valid, mem_rdata);
                end
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ram_read();
        test_unmapped();
        test_io_write();
        test_back_to_back();
        test_reset_mid_wait();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
